// File: rtl/alu_checker.sv
// alu_checker
//   Result checker for the 8-bit, 3-bit-opcode ALU. Samples each
//   operand/result tuple on valid while running, recomputes the golden
//   {carry,result} and compares it against the ALU's {cout,sum}.
//   Keeps saturating check/error counters, a sticky fail flag and,
//   optionally, a capture of the first failing tuple.
//
// Parameters
//   CNT_W        width of chk_cnt / err_cnt
//   STOP_ON_ERR  1: halt on the first mismatch, ignoring further tuples
//
// Build option
//   ALU_CHK_CAPTURE_EN  defined: fail_oper/fail_a/fail_b/fail_exp capture
//                       the first mismatching tuple; undefined: they are 0
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start, stop        control pulses (start clears and runs, stop idles)
//   valid              tuple present on oper/a/b/cin/sum/cout
//   oper, a, b, cin    ALU inputs
//   sum, cout          ALU outputs under test
//   busy               high while running
//   chk_cnt, err_cnt   tuples checked / tuples mismatching
//   fail               sticky first-mismatch flag
//   fail_oper/a/b/exp  first mismatching tuple and its expected {cout,sum}
//
// state | meaning
// IDLE  | not checking, counters held
// RUN   | checking every valid tuple
// HALT  | stopped on mismatch (STOP_ON_ERR), valid ignored
module alu_checker #(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             valid,
  input  logic [2:0]       oper,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             cin,
  input  logic [7:0]       sum,
  input  logic             cout,
  output logic             busy,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail,
  output logic [2:0]       fail_oper,
  output logic [7:0]       fail_a,
  output logic [7:0]       fail_b,
  output logic [8:0]       fail_exp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state_q, state_d;
  logic [8:0] golden;
  logic       mismatch;
  logic       check_en;

  always_comb begin
    golden = '0;
    case (oper)
      3'b000: golden = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      // Bit 8 of the 9-bit difference is the borrow.
      3'b001: golden = {1'b0, a} - {1'b0, b} - {8'd0, cin};
      3'b010: golden = {1'b0, a & b};
      3'b011: golden = {1'b0, a | b};
      3'b100: golden = {1'b0, a ^ b};
      3'b101: golden = {1'b0, ~a};
      3'b110: golden = {a[7], a[6:0], 1'b0};
      3'b111: golden = {a[0], 1'b0, a[7:1]};
      default: golden = '0;
    endcase
  end

  assign mismatch = ({cout, sum} != golden);
  // A start in RUN restarts the run; the tuple in that cycle is dropped.
  assign check_en = (state_q == ST_RUN) && valid && !start;
  assign busy     = (state_q == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (start)                                   state_d = ST_RUN;
        else if (stop)                               state_d = ST_IDLE;
        else if (STOP_ON_ERR && valid && mismatch)   state_d = ST_HALT;
      end
      ST_HALT: begin
        if (start)     state_d = ST_RUN;
        else if (stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt <= '0;
      err_cnt <= '0;
      fail    <= 1'b0;
    end else if (start) begin
      chk_cnt <= '0;
      err_cnt <= '0;
      fail    <= 1'b0;
    end else if (check_en) begin
      if (chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + CNT_W'(1);
      if (mismatch) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
        fail <= 1'b1;
      end
    end
  end

`ifdef ALU_CHK_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_oper <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_exp  <= '0;
    end else if (start) begin
      fail_oper <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_exp  <= '0;
    end else if (check_en && mismatch && !fail) begin
      fail_oper <= oper;
      fail_a    <= a;
      fail_b    <= b;
      fail_exp  <= golden;
    end
  end
`else
  assign fail_oper = '0;
  assign fail_a    = '0;
  assign fail_b    = '0;
  assign fail_exp  = '0;
`endif

endmodule

// File: tb/tb_alu_checker.sv
// Testbench for alu_checker: three instances share one stimulus stream
// (default, STOP_ON_ERR=1, CNT_W=4). The default instance is tracked by a
// bench-side model feeding a scoreboard queue; the other two are checked
// at directed points against fixed values.
module tb_alu_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, valid = 1'b0;
  logic [2:0] oper = '0;
  logic [7:0] a = '0, b = '0, sum = '0;
  logic       cin = 1'b0, cout = 1'b0;

  logic        m_busy, m_fail;
  logic [15:0] m_chk, m_err;
  logic [2:0]  m_foper;
  logic [7:0]  m_fa, m_fb;
  logic [8:0]  m_fexp;

  logic        s_busy, s_fail;
  logic [15:0] s_chk, s_err;
  logic [2:0]  s_foper;
  logic [7:0]  s_fa, s_fb;
  logic [8:0]  s_fexp;

  logic        t_busy, t_fail;
  logic [3:0]  t_chk, t_err;
  logic [2:0]  t_foper;
  logic [7:0]  t_fa, t_fb;
  logic [8:0]  t_fexp;

  always #5 clk = ~clk;

  alu_checker u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .valid(valid),
    .oper(oper), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(m_busy), .chk_cnt(m_chk), .err_cnt(m_err), .fail(m_fail),
    .fail_oper(m_foper), .fail_a(m_fa), .fail_b(m_fb), .fail_exp(m_fexp)
  );

  alu_checker #(.STOP_ON_ERR(1'b1)) u_soe (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .valid(valid),
    .oper(oper), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(s_busy), .chk_cnt(s_chk), .err_cnt(s_err), .fail(s_fail),
    .fail_oper(s_foper), .fail_a(s_fa), .fail_b(s_fb), .fail_exp(s_fexp)
  );

  alu_checker #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .valid(valid),
    .oper(oper), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(t_busy), .chk_cnt(t_chk), .err_cnt(t_err), .fail(t_fail),
    .fail_oper(t_foper), .fail_a(t_fa), .fail_b(t_fb), .fail_exp(t_fexp)
  );

  typedef struct {
    logic [15:0] chk;
    logic [15:0] err;
    logic        fail;
    logic [2:0]  oper;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [8:0]  exp;
  } exp_t;

  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  bit          md_run = 1'b0;
  logic [15:0] md_chk = '0, md_err = '0;
  logic        md_fail = 1'b0;
  logic [2:0]  md_oper = '0;
  logic [7:0]  md_a = '0, md_b = '0;
  logic [8:0]  md_exp = '0;

  function automatic logic [8:0] ref_result(input logic [2:0] op, input logic [7:0] x,
                                            input logic [7:0] y, input logic ci);
    int r;
    case (op)
      3'd0: r = int'(x) + int'(y) + int'(ci);
      3'd1: begin
        r = int'(x) - int'(y) - int'(ci);
        if (r < 0) r = r + 512;
      end
      3'd2: r = int'(x & y);
      3'd3: r = int'(x | y);
      3'd4: r = int'(x ^ y);
      3'd5: r = 255 - int'(x);
      3'd6: r = int'(x) * 2;
      default: r = int'(x) / 2 + (int'(x) % 2) * 256;
    endcase
    return r[8:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    md_chk = '0; md_err = '0; md_fail = 1'b0;
    md_oper = '0; md_a = '0; md_b = '0; md_exp = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    md_run = 1'b1;
    model_clear();
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stop = 1'b0;
    md_run = 1'b0;
  endtask

  // Drives one tuple for one cycle (valid is left high so consecutive calls
  // are back-to-back), then pops the scoreboard and compares the main DUT.
  task automatic send(input string tag, input logic [2:0] op, input logic [7:0] x,
                      input logic [7:0] y, input logic ci, input logic [7:0] s,
                      input logic co);
    exp_t e;
    logic [8:0] g;
    oper = op; a = x; b = y; cin = ci; sum = s; cout = co; valid = 1'b1;
    if (md_run) begin
      g = ref_result(op, x, y, ci);
      if (md_chk != 16'hFFFF) md_chk = md_chk + 16'd1;
      if ({co, s} != g) begin
        if (md_err != 16'hFFFF) md_err = md_err + 16'd1;
        if (!md_fail) begin
          md_oper = op; md_a = x; md_b = y; md_exp = g;
        end
        md_fail = 1'b1;
      end
    end
    e.chk = md_chk; e.err = md_err; e.fail = md_fail;
    e.oper = md_oper; e.a = md_a; e.b = md_b; e.exp = md_exp;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check({tag, ".chk"},  64'(m_chk),  64'(e.chk));
    check({tag, ".err"},  64'(m_err),  64'(e.err));
    check({tag, ".fail"}, 64'(m_fail), 64'(e.fail));
`ifdef ALU_CHK_CAPTURE_EN
    check({tag, ".cap"}, 64'({m_foper, m_fa, m_fb, m_fexp}), 64'({e.oper, e.a, e.b, e.exp}));
`else
    check({tag, ".cap"}, 64'({m_foper, m_fa, m_fb, m_fexp}), 64'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (2) @(negedge clk);
    check("rst.main", 64'({m_busy, m_chk, m_err, m_fail, m_foper, m_fa, m_fb, m_fexp}), 64'(0));
    check("rst.sat", 64'({t_busy, t_chk, t_err, t_fail}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    send("idle_valid", 3'b000, 8'h01, 8'h01, 1'b0, 8'h55, 1'b0);
    valid = 1'b0;
    check("idle.busy", 64'(m_busy), 64'(0));

    // Correct ADD/SUB
    pulse_start();
    check("start.busy", 64'({m_busy, s_busy, t_busy}), 64'b111);
    send("add_ok", 3'b000, 8'h75, 8'hF0, 1'b0, 8'h65, 1'b1);
    send("sub_ok", 3'b001, 8'h10, 8'h20, 1'b1, 8'hEF, 1'b1);
    valid = 1'b0;
    check("addsub.chk", 64'(m_chk), 64'd2);
    check("addsub.err", 64'({m_err, m_fail}), 64'd0);

    // Mismatch capture: SHL carry wrong, then AND result wrong
    send("shl_bad", 3'b110, 8'h81, 8'h00, 1'b0, 8'h02, 1'b0);
    send("and_bad", 3'b010, 8'hFF, 8'h0F, 1'b0, 8'h00, 1'b0);
    valid = 1'b0;
    check("cap.err", 64'(m_err), 64'd2);
    check("cap.fail", 64'(m_fail), 64'd1);
`ifdef ALU_CHK_CAPTURE_EN
    check("cap.oper", 64'(m_foper), 64'd6);
    check("cap.a", 64'(m_fa), 64'h81);
    check("cap.exp", 64'(m_fexp), 64'h102);
`endif
    check("soe.halt_busy", 64'(s_busy), 64'd0);
    check("soe.halt_cnt", 64'({s_chk, s_err}), 64'({16'd3, 16'd1}));

    // stop holds counters; valid in IDLE ignored
    pulse_stop();
    check("stop.busy", 64'(m_busy), 64'd0);
    send("stopped_valid", 3'b100, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0);
    valid = 1'b0;

    // STOP_ON_ERR: bad NOT then five good XORs
    pulse_start();
    send("not_bad", 3'b101, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] xa;
      xa = 8'(i * 17 + 3);
      send("xor_ok", 3'b100, xa, 8'h5A, 1'b0, xa ^ 8'h5A, 1'b0);
    end
    valid = 1'b0;
    check("soe.busy", 64'(s_busy), 64'd0);
    check("soe.cnt", 64'({s_chk, s_err}), 64'({16'd1, 16'd1}));

    // Saturation on the CNT_W=4 instance
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] xa;
      xa = 8'(i);
      send("sat_bad", 3'b011, xa, 8'h01, 1'b0, (xa | 8'h01) ^ 8'hFF, 1'b0);
    end
    valid = 1'b0;
    check("sat.cnt", 64'({t_chk, t_err}), 64'hFF);
    check("main.nosat", 64'({m_chk, m_err}), 64'({16'd20, 16'd20}));
    pulse_start();
    check("sat.clear", 64'({t_chk, t_err, t_fail}), 64'd0);

    // Restart with a valid tuple in the same cycle: tuple dropped
    send("pre_restart", 3'b000, 8'h01, 8'h02, 1'b0, 8'h00, 1'b0);
    oper = 3'b000; a = 8'h10; b = 8'h10; sum = 8'h00; cout = 1'b0; valid = 1'b1;
    pulse_start();
    valid = 1'b0;
    check("restart.cnt", 64'({m_chk, m_err, m_fail}), 64'd0);
    check("restart.busy", 64'(m_busy), 64'd1);

    // Asynchronous reset between edges mid-run
    send("pre_reset", 3'b111, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0);
    valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.main", 64'({m_busy, m_chk, m_err, m_fail, m_foper, m_fa, m_fb, m_fexp}), 64'(0));
    check("arst.others", 64'({s_busy, s_chk, t_busy, t_chk}), 64'(0));
    md_run = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start and stop together: start wins
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    md_run = 1'b1;
    model_clear();
    check("startstop.busy", 64'(m_busy), 64'd1);
    send("post_ss", 3'b001, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    valid = 1'b0;
    pulse_stop();
    check("final.busy", 64'(m_busy), 64'd0);
    check("final.chk", 64'(m_chk), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
